// File: rtl/hazard_ctrl.sv
// Hazard and control unit for the 5-stage pipeline: stalls, bubbles,
// flushes, mult/div tracking, precise interrupt take and stall counter.
module hazard_ctrl #(
   parameter int AW         = 5,
   parameter int LINK_REG   = 31,
   parameter int MD_LAT     = 32,
   parameter int BR_FWD_MEM = 1,
   parameter int CW         = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] rs_id,
   input  logic [AW-1:0] rt_id,
   input  logic          branch_id,
   input  logic          jr_id,
   input  logic [2:0]    pcsrc_id,
   input  logic          md_use_id,
   input  logic          memread_ex,
   input  logic          regwrite_ex,
   input  logic [AW-1:0] wa_ex,
   input  logic          md_start_ex,
   input  logic          memread_mem,
   input  logic          regwrite_mem,
   input  logic          link_mem,
   input  logic [AW-1:0] wa_mem,
   input  logic          irq,
   input  logic          perf_clr,
   output logic          stall,
   output logic          bubble_ex,
   output logic          flush_id,
   output logic          flush_all,
   output logic          irq_take,
   output logic          md_busy,
   output logic [CW-1:0] stall_cnt
);

   localparam int MW = $clog2(MD_LAT + 1);
   localparam logic [AW-1:0] LinkReg = AW'(LINK_REG);
   localparam logic [MW-1:0] MdLoad = MW'(MD_LAT);
   localparam logic BrFwd = (BR_FWD_MEM != 0);

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      TAKE,
      WAITLOW
   } irqState_t;

   irqState_t state, stateNxt;
   logic [MW-1:0] mdCnt;
   logic [CW-1:0] stallCnt;

   logic rsNz, rtNz;
   logic rsLoad, rtLoad;
   logic rsBr, rtBr;
   logic hzMd, hz;
   logic take, mdBusy, stallInt;

   assign rsNz = |rs_id;
   assign rtNz = |rt_id;

   assign rsLoad = rsNz && memread_ex && (wa_ex == rs_id);
   assign rtLoad = rtNz && memread_ex && (wa_ex == rt_id);

   // Sources the ID-stage compare cannot yet see through forwarding
   assign rsBr = rsNz && ((regwrite_ex && (wa_ex == rs_id))
              || (memread_mem && (wa_mem == rs_id))
              || (link_mem && (rs_id == LinkReg))
              || (!BrFwd && regwrite_mem && (wa_mem == rs_id)));
   assign rtBr = rtNz && ((regwrite_ex && (wa_ex == rt_id))
              || (memread_mem && (wa_mem == rt_id))
              || (link_mem && (rt_id == LinkReg))
              || (!BrFwd && regwrite_mem && (wa_mem == rt_id)));

   assign mdBusy = (mdCnt != '0);
   assign hzMd = md_use_id && (mdBusy || md_start_ex);

   assign hz = rsLoad || rtLoad
            || (branch_id && (rsBr || rtBr))
            || (jr_id && rsBr)
            || hzMd;

   assign take = (state == TAKE);
   assign stallInt = hz && !take;

   assign stall     = reset && stallInt;
   assign bubble_ex = reset && stallInt;
   assign flush_id  = reset && (pcsrc_id != 3'd0)
                    && !stallInt && !take;
   assign flush_all = reset && take;
   assign irq_take  = reset && take;
   assign md_busy   = reset && mdBusy;
   assign stall_cnt = stallCnt;

   always_comb begin
      stateNxt = state;
      unique case (state)
         IDLE:    if (irq) stateNxt = PEND;
         PEND: begin
            if (!irq)
               stateNxt = IDLE;
            else if (!hz && (pcsrc_id == 3'd0) && !mdBusy)
               stateNxt = TAKE;
         end
         TAKE:    stateNxt = WAITLOW;
         WAITLOW: if (!irq) stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= stateNxt;
   end

   // An issuing mult/div in TAKE is being flushed, so it never loads
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         mdCnt <= '0;
      else if (md_start_ex && !take)
         mdCnt <= MdLoad;
      else if (mdBusy)
         mdCnt <= mdCnt - MW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stallCnt <= '0;
      else if (perf_clr)
         stallCnt <= '0;
      else if (stallInt && !(&stallCnt))
         stallCnt <= stallCnt + CW'(1);
   end

endmodule
